slot_game_ctrl: RTL and testbench

Game controller for the slot machine: owns the credit count, turns raw coin/start buttons into single-cycle events, fires the start pulse into the slot body, watches the spin, grades the three reel values when all reels stop and pays out credits one at a time. Sits between the board push-buttons/display and the slot body. Its `slot_start` output drives the slot body start-trigger input. The slot body's `run_stop`, `fever` and reel outputs feed back into this block.

---
 rtl/slot_game_ctrl_pkg.sv | 44 ++++
 rtl/slot_game_ctrl_if.sv | 30 +++
 rtl/slot_game_ctrl_btn_edge.sv | 25 ++
 rtl/slot_game_ctrl.sv | 158 +++++++++++++++
 tb/tb_slot_game_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/slot_game_ctrl_pkg.sv
// Shared types, default parameters and the reel grading rule for the slot game controller.
package slot_game_ctrl_pkg;

    localparam int REEL_W   = 3;
    localparam int CREDIT_W = 8;
    localparam int CNT_W    = 8;

    localparam int DEF_CREDIT_MAX = 99;
    localparam int DEF_WIN3_PAY   = 10;
    localparam int DEF_WIN2_PAY   = 2;
    localparam int DEF_PAY_GAP    = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_SPIN_WAIT = 3'd2,
        ST_SPIN      = 3'd3,
        ST_EVAL      = 3'd4,
        ST_PAYOUT    = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        GR_NONE   = 2'd0,
        GR_PAIR   = 2'd1,
        GR_TRIPLE = 2'd2
    } grade_t;

    // The slot body's fever flag is trusted for the triple; pairs come from the raw reel values.
    function automatic grade_t grade_reels(
        input logic              fever,
        input logic [REEL_W-1:0] l,
        input logic [REEL_W-1:0] m,
        input logic [REEL_W-1:0] r
    );
        if (fever) begin
            return GR_TRIPLE;
        end
        if ((l == m) || (m == r) || (l == r)) begin
            return GR_PAIR;
        end
        return GR_NONE;
    endfunction

endpackage

// File: rtl/slot_game_ctrl_if.sv
// Board/slot-body side signals of the game controller, bundled with directional modports.
interface slot_game_ctrl_if;
    import slot_game_ctrl_pkg::*;

    logic                coin_btn;
    logic                start_btn;
    logic                run_stop;
    logic                fever;
    logic [REEL_W-1:0]   left;
    logic [REEL_W-1:0]   middle;
    logic [REEL_W-1:0]   right;

    logic                slot_start;
    logic [CREDIT_W-1:0] credit;
    logic                paying;
    logic                win3;
    logic                win2;
    logic [2:0]          state;

    modport master (
        output coin_btn, start_btn, run_stop, fever, left, middle, right,
        input  slot_start, credit, paying, win3, win2, state
    );

    modport slave (
        input  coin_btn, start_btn, run_stop, fever, left, middle, right,
        output slot_start, credit, paying, win3, win2, state
    );

endinterface

// File: rtl/slot_game_ctrl_btn_edge.sv
// Two-flop synchroniser for a raw push-button followed by a registered rising-edge pulse.
module btn_edge (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic pulse
);

    // r_pipe[0..1] synchronise, r_pipe[2] remembers the previous synchronised level.
    logic [2:0] r_pipe;
    logic       r_pulse;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pipe  <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_pipe  <= {r_pipe[1:0], raw};
            r_pulse <= r_pipe[1] & ~r_pipe[2];
        end
    end

    assign pulse = r_pulse;

endmodule

// File: rtl/slot_game_ctrl.sv
// Slot machine game controller: credit counter, start launch, spin tracking, grading and paced payout.
module slot_game_ctrl
    import slot_game_ctrl_pkg::*;
#(
    parameter int CREDIT_MAX = DEF_CREDIT_MAX,
    parameter int WIN3_PAY   = DEF_WIN3_PAY,
    parameter int WIN2_PAY   = DEF_WIN2_PAY,
    parameter int PAY_GAP    = DEF_PAY_GAP
) (
    input  logic            clock,
    input  logic            reset,
    slot_game_ctrl_if.slave bus
);

    localparam int N_BTN     = 2;
    localparam int BTN_COIN  = 0;
    localparam int BTN_START = 1;
    localparam int SUM_W     = CREDIT_W + 2;

    logic [N_BTN-1:0]    w_btn_raw;
    logic [N_BTN-1:0]    w_btn_ev;
    logic                w_coin_ev;
    logic                w_start_ev;
    logic                w_accept;
    logic                w_tick;
    grade_t              w_grade;
    logic [CNT_W-1:0]    w_pay;
    logic [SUM_W-1:0]    w_sum;
    logic [CREDIT_W-1:0] w_credit_next;

    state_t              r_state;
    logic                r_slot_start;
    logic                r_paying;
    logic                r_win3;
    logic                r_win2;
    logic [CREDIT_W-1:0] r_credit;
    logic [CNT_W-1:0]    r_pay_left;
    logic [CNT_W-1:0]    r_gap;

    assign w_btn_raw[BTN_COIN]  = bus.coin_btn;
    assign w_btn_raw[BTN_START] = bus.start_btn;

    genvar gi;
    generate
        for (gi = 0; gi < N_BTN; gi++) begin : g_btn
            btn_edge u_btn (
                .clock (clock),
                .reset (reset),
                .raw   (w_btn_raw[gi]),
                .pulse (w_btn_ev[gi])
            );
        end
    endgenerate

    assign w_coin_ev  = w_btn_ev[BTN_COIN];
    assign w_start_ev = w_btn_ev[BTN_START];

    assign w_accept = (r_state == ST_IDLE) && w_start_ev && (r_credit != '0);
    assign w_tick   = (r_state == ST_PAYOUT) && (r_gap == '0);

    // Single adder for every credit source; a start only ever removes one credit that exists.
    always_comb begin
        w_sum = SUM_W'(r_credit) + SUM_W'(w_coin_ev) + SUM_W'(w_tick) - SUM_W'(w_accept);
        w_credit_next = r_credit;
        if (w_sum[SUM_W-1]) begin
            w_credit_next = '0;
        end else if (w_sum > SUM_W'(CREDIT_MAX)) begin
            w_credit_next = CREDIT_W'(CREDIT_MAX);
        end else begin
            w_credit_next = w_sum[CREDIT_W-1:0];
        end
    end

    assign w_grade = grade_reels(bus.fever, bus.left, bus.middle, bus.right);

    always_comb begin
        w_pay = '0;
        case (w_grade)
            GR_TRIPLE: w_pay = CNT_W'(WIN3_PAY);
            GR_PAIR:   w_pay = CNT_W'(WIN2_PAY);
            default:   w_pay = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_slot_start <= 1'b0;
            r_paying     <= 1'b0;
            r_win3       <= 1'b0;
            r_win2       <= 1'b0;
            r_credit     <= '0;
            r_pay_left   <= '0;
            r_gap        <= '0;
        end else begin
            r_credit     <= w_credit_next;
            r_slot_start <= w_accept;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_LAUNCH;
                        r_win3  <= 1'b0;
                        r_win2  <= 1'b0;
                    end
                end
                ST_LAUNCH: begin
                    r_state <= ST_SPIN_WAIT;
                end
                ST_SPIN_WAIT: begin
                    if (bus.run_stop) begin
                        r_state <= ST_SPIN;
                    end
                end
                ST_SPIN: begin
                    if (!bus.run_stop) begin
                        r_state <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    r_win3 <= (w_grade == GR_TRIPLE);
                    r_win2 <= (w_grade == GR_PAIR);
                    if (w_pay != '0) begin
                        r_state    <= ST_PAYOUT;
                        r_paying   <= 1'b1;
                        r_pay_left <= w_pay;
                        r_gap      <= CNT_W'(PAY_GAP - 1);
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_PAYOUT: begin
                    // The gap timer counts down to zero; the zero cycle is the payout tick.
                    if (w_tick) begin
                        r_gap      <= CNT_W'(PAY_GAP - 1);
                        r_pay_left <= r_pay_left - 1'b1;
                        if (r_pay_left == CNT_W'(1)) begin
                            r_state  <= ST_IDLE;
                            r_paying <= 1'b0;
                        end
                    end else begin
                        r_gap <= r_gap - 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.slot_start = r_slot_start;
    assign bus.credit     = r_credit;
    assign bus.paying     = r_paying;
    assign bus.win3       = r_win3;
    assign bus.win2       = r_win2;
    assign bus.state      = r_state;

endmodule

// File: tb/tb_slot_game_ctrl.sv
// Self-checking bench for slot_game_ctrl: directed scenarios plus randomized games against a game-level model.
module tb_slot_game_ctrl;
    import slot_game_ctrl_pkg::*;

    localparam int CMAX = 99;
    localparam int W3   = 10;
    localparam int W2   = 2;
    localparam int GAP  = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    slot_game_ctrl_if bus();

    slot_game_ctrl #(
        .CREDIT_MAX (CMAX),
        .WIN3_PAY   (W3),
        .WIN2_PAY   (W2),
        .PAY_GAP    (GAP)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Game-level model: button history, phase number, credits and payout progress.
    typedef struct packed {
        int       phase;
        int       credit;
        int       left;
        int       elapsed;
        bit       ss;
        bit       pay;
        bit       w3;
        bit       w2;
        bit [3:0] ch;
        bit [3:0] sh;
    } model_t;

    model_t m;
    bit     m_valid = 1'b0;

    function automatic model_t model_step(input model_t cur, input bit coin_raw, input bit start_raw,
                                          input bit rs, input bit fv, input int l, input int mi, input int r);
        model_t nx;
        int     delta;
        int     nmatch;
        int     pay;
        bit     cev;
        bit     sev;
        nx     = cur;
        cev    = cur.ch[2] & ~cur.ch[3];
        sev    = cur.sh[2] & ~cur.sh[3];
        delta  = int'(cev);
        nx.ss  = 1'b0;
        case (cur.phase)
            0: if (sev && cur.credit > 0) begin
                delta -= 1;
                nx.w3 = 1'b0;
                nx.w2 = 1'b0;
                nx.phase = 1;
                nx.ss = 1'b1;
            end
            1: nx.phase = 2;
            2: if (rs) nx.phase = 3;
            3: if (!rs) nx.phase = 4;
            4: begin
                nmatch = int'(l == mi) + int'(mi == r) + int'(l == r);
                pay = fv ? W3 : ((nmatch > 0) ? W2 : 0);
                nx.w3 = fv;
                nx.w2 = !fv && (nmatch > 0);
                if (pay > 0) begin
                    nx.phase = 5;
                    nx.pay = 1'b1;
                    nx.left = pay;
                    nx.elapsed = 0;
                end else begin
                    nx.phase = 0;
                end
            end
            5: begin
                nx.elapsed = cur.elapsed + 1;
                if (nx.elapsed == GAP) begin
                    nx.elapsed = 0;
                    delta += 1;
                    nx.left = cur.left - 1;
                    if (nx.left == 0) begin
                        nx.phase = 0;
                        nx.pay = 1'b0;
                    end
                end
            end
            default: nx.phase = 0;
        endcase
        nx.credit = cur.credit + delta;
        if (nx.credit > CMAX) nx.credit = CMAX;
        if (nx.credit < 0) nx.credit = 0;
        nx.ch = {cur.ch[2:0], coin_raw};
        nx.sh = {cur.sh[2:0], start_raw};
        return nx;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m       <= '0;
            m_valid <= 1'b1;
        end else begin
            m <= model_step(m, bus.coin_btn, bus.start_btn, bus.run_stop, bus.fever,
                            int'(bus.left), int'(bus.middle), int'(bus.right));
        end
    end

    always @(negedge clock) begin
        if (m_valid) begin
            check("credit", int'(bus.credit), m.credit);
            check("state", int'(bus.state), m.phase);
            check("slot_start", int'(bus.slot_start), int'(m.ss));
            check("paying", int'(bus.paying), int'(m.pay));
            check("win3", int'(bus.win3), int'(m.w3));
            check("win2", int'(bus.win2), int'(m.w2));
        end
    end

    int ss_count  = 0;
    int pay_count = 0;
    always @(negedge clock) begin
        if (bus.slot_start === 1'b1) ss_count++;
        if (bus.paying === 1'b1) pay_count++;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic coin(input int hold);
        bus.coin_btn = 1'b1;
        cyc(hold);
        bus.coin_btn = 1'b0;
        cyc(2);
    endtask

    task automatic wait_state(input int code, input int budget, input string name, input bit noise);
        int n = 0;
        while (int'(bus.state) != code && n < budget) begin
            if (noise) bus.coin_btn = ($urandom_range(0, 3) == 0);
            cyc(1);
            n++;
        end
        bus.coin_btn = 1'b0;
        check(name, int'(bus.state), code);
    endtask

    task automatic play(input int l, input int mi, input int r, input int len, input bit noise, input int rst_at);
        bus.start_btn = 1'b1;
        cyc(1);
        bus.start_btn = 1'b0;
        wait_state(2, 20, "launch", 1'b0);
        cyc($urandom_range(0, 3));
        bus.run_stop = 1'b1;
        for (int i = 0; i < len; i++) begin
            if (noise) begin
                bus.coin_btn  = ($urandom_range(0, 3) == 0);
                bus.start_btn = (i < len - 4) && ($urandom_range(0, 4) == 0);
            end
            bus.left   = 3'($urandom_range(0, 7));
            bus.middle = 3'($urandom_range(0, 7));
            bus.right  = 3'($urandom_range(0, 7));
            bus.fever  = 1'b0;
            if (i == rst_at) reset = 1'b1;
            cyc(1);
            reset = 1'b0;
        end
        bus.coin_btn  = 1'b0;
        bus.start_btn = 1'b0;
        bus.left   = 3'(l);
        bus.middle = 3'(mi);
        bus.right  = 3'(r);
        bus.fever  = (l == mi) && (mi == r);
        cyc(1);
        bus.run_stop = 1'b0;
        wait_state(0, 200, "game_end", noise);
        cyc(4);
    endtask

    int c4, c5, n, k, mode, gl, gm, gr, glen, grst;

    initial begin
        bus.coin_btn = 1'b0; bus.start_btn = 1'b0; bus.run_stop = 1'b0; bus.fever = 1'b0;
        bus.left = '0; bus.middle = '0; bus.right = '0;
        cyc(3);
        reset = 1'b0;
        cyc(1);
        check("rst_credit", int'(bus.credit), 0);
        check("rst_state", int'(bus.state), 0);

        repeat (3) coin(1);
        cyc(5);
        check("coin3", int'(bus.credit), 3);
        coin(50);
        cyc(5);
        check("coin_hold", int'(bus.credit), 4);
        repeat (120) coin(1);
        cyc(5);
        check("coin_sat", int'(bus.credit), 99);

        reset = 1'b1; cyc(1); reset = 1'b0;
        check("rst2_credit", int'(bus.credit), 0);

        ss_count = 0;
        bus.start_btn = 1'b1; cyc(2); bus.start_btn = 1'b0; cyc(8);
        check("nocred_ss", ss_count, 0);
        check("nocred_state", int'(bus.state), 0);

        repeat (2) coin(1);
        cyc(5);
        check("two_coins", int'(bus.credit), 2);
        ss_count = 0;
        play(1, 4, 6, 20, 1'b0, -1);
        check("lose_credit", int'(bus.credit), 1);
        check("lose_w3", int'(bus.win3), 0);
        check("lose_w2", int'(bus.win2), 0);
        check("lose_ss", ss_count, 1);

        pay_count = 0;
        play(5, 5, 5, 20, 1'b0, -1);
        check("tri_w3", int'(bus.win3), 1);
        check("tri_paycyc", pay_count, 40);
        check("tri_credit", int'(bus.credit), 10);

        bus.start_btn = 1'b1; cyc(1); bus.start_btn = 1'b0;
        wait_state(2, 20, "pair_launch", 1'b0);
        bus.run_stop = 1'b1;
        cyc(10);
        bus.left = 3'd2; bus.middle = 3'd2; bus.right = 3'd7; bus.fever = 1'b0;
        cyc(1);
        bus.run_stop = 1'b0;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (bus.paying !== 1'b1 && n < 50);
        check("pair_pay_on", int'(bus.paying), 1);
        bus.coin_btn = 1'b1;
        bus.start_btn = 1'b1;
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        c4 = int'(bus.credit);
        bus.coin_btn = 1'b0;
        bus.start_btn = 1'b0;
        @(negedge clock);
        c5 = int'(bus.credit);
        check("tick_plus_coin", c5 - c4, 2);
        wait_state(0, 100, "pair_idle", 1'b0);
        cyc(5);
        check("pair_credit", int'(bus.credit), 12);
        check("pair_w2", int'(bus.win2), 1);
        check("pair_w3", int'(bus.win3), 0);

        bus.start_btn = 1'b1; cyc(1); bus.start_btn = 1'b0;
        wait_state(2, 20, "rst_launch", 1'b0);
        bus.run_stop = 1'b1;
        wait_state(3, 10, "rst_spin", 1'b0);
        cyc(3);
        reset = 1'b1; cyc(1); reset = 1'b0;
        check("midrst_state", int'(bus.state), 0);
        check("midrst_credit", int'(bus.credit), 0);
        check("midrst_w2", int'(bus.win2), 0);
        check("midrst_pay", int'(bus.paying), 0);
        bus.run_stop = 1'b0;
        cyc(6);
        check("midrst_noeval", int'(bus.state), 0);

        for (int g = 0; g < 30; g++) begin
            k = $urandom_range(0, 2);
            repeat (k) coin($urandom_range(1, 3));
            cyc(4);
            mode = $urandom_range(0, 2);
            gl = $urandom_range(0, 7);
            gm = (mode == 0) ? gl : $urandom_range(0, 7);
            gr = (mode == 0) ? gl : ((mode == 1) ? gm : $urandom_range(0, 7));
            glen = $urandom_range(5, 15);
            grst = ($urandom_range(0, 7) == 0) ? $urandom_range(0, glen - 1) : -1;
            if (m.credit == 0) begin
                bus.start_btn = 1'b1; cyc(1); bus.start_btn = 1'b0;
                cyc(6);
                check("rand_nocred", int'(bus.state), 0);
            end else begin
                play(gl, gm, gr, glen, 1'b1, grst);
            end
        end

        cyc(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
